// File: rtl/stall_sched.sv
// Pipeline stall scheduler: arbitrates hazard, multi-cycle, memory-wait and flush stalls into stallb_en.
// Optional stalled-cycle counter enabled by defining STALL_SCHED_PERF_EN.
module stall_sched #(
  parameter int unsigned HAZ_BUBBLES  = 1,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned MC_W         = 4,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             ld_use_hz,
  input  logic             mc_req,
  input  logic [MC_W-1:0]  mc_len,
  output logic             mc_ack,
  input  logic             mem_wait,
  input  logic             flush_req,
  output logic             stallb_en,
  output logic [2:0]       stall_src,
  output logic [CNT_W-1:0] stall_cnt
);

  // Down-counter must hold both the 4-bit bubble/drain constants and any mc_len.
  localparam int unsigned DW = (MC_W > 4) ? MC_W : 4;
  localparam logic [DW-1:0] ONE = DW'(1);

  typedef enum logic [2:0] {
    S_RUN   = 3'd0,
    S_HAZ   = 3'd1,
    S_MC    = 3'd2,
    S_MEMW  = 3'd3,
    S_FLUSH = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic [DW-1:0] dcnt, dcnt_nx;
  logic [DW-1:0] mc_load;
  logic          ack_nx;

  always_comb begin
    mc_load = (mc_len == '0) ? ONE : DW'(mc_len);
  end

  always_comb begin
    state_nx = state;
    dcnt_nx  = dcnt;
    ack_nx   = 1'b0;
    if (flush_req) begin
      state_nx = S_FLUSH;
      dcnt_nx  = DW'(DRAIN_CYCLES);
    end else begin
      case (state)
        S_RUN: begin
          if (mem_wait) begin
            state_nx = S_MEMW;
          end else if (mc_req) begin
            state_nx = S_MC;
            dcnt_nx  = mc_load;
            ack_nx   = 1'b1;
          end else if (ld_use_hz) begin
            state_nx = S_HAZ;
            dcnt_nx  = DW'(HAZ_BUBBLES);
          end
        end
        S_MEMW: begin
          if (!mem_wait) state_nx = S_RUN;
        end
        S_HAZ, S_MC, S_FLUSH: begin
          // Every counted episode returns to RUN, guaranteeing one run cycle between stalls.
          if (dcnt == ONE) begin
            state_nx = S_RUN;
            dcnt_nx  = '0;
          end else begin
            dcnt_nx = dcnt - ONE;
          end
        end
        default: begin
          state_nx = S_RUN;
          dcnt_nx  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      state     <= S_RUN;
      dcnt      <= '0;
      mc_ack    <= 1'b0;
      stallb_en <= 1'b1;
      stall_src <= 3'd0;
    end else begin
      state     <= state_nx;
      dcnt      <= dcnt_nx;
      mc_ack    <= ack_nx;
      stallb_en <= (state_nx == S_RUN);
      stall_src <= state_nx;
    end
  end

`ifdef STALL_SCHED_PERF_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (!stallb_en && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    stall_cnt = cnt_q;
  end
`else
  always_comb begin
    stall_cnt = '0;
  end
`endif

endmodule

// File: tb/tb_stall_sched.sv
// Self-checking bench for stall_sched: directed literal scenarios plus randomized traffic vs. an episode model.
module tb_stall_sched;

  localparam int unsigned HAZ   = 1;
  localparam int unsigned DRAIN = 3;
  localparam int unsigned MCW   = 4;
  localparam int unsigned CNTW  = 8;
  localparam int          CMAX  = (1 << CNTW) - 1;

  logic            clk_in = 1'b0;
  logic            rst;
  logic            ld_use_hz;
  logic            mc_req;
  logic [MCW-1:0]  mc_len;
  logic            mc_ack;
  logic            mem_wait;
  logic            flush_req;
  logic            stallb_en;
  logic [2:0]      stall_src;
  logic [CNTW-1:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  stall_sched #(
    .HAZ_BUBBLES (HAZ),
    .DRAIN_CYCLES(DRAIN),
    .MC_W        (MCW),
    .CNT_W       (CNTW)
  ) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .ld_use_hz(ld_use_hz),
    .mc_req   (mc_req),
    .mc_len   (mc_len),
    .mc_ack   (mc_ack),
    .mem_wait (mem_wait),
    .flush_req(flush_req),
    .stallb_en(stallb_en),
    .stall_src(stall_src),
    .stall_cnt(stall_cnt)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Episode model: which stall source is active and how many stall cycles remain.
  int m_src  = 0;
  int m_left = 0;
  int m_ack  = 0;
  int m_cnt  = 0;

  always @(posedge clk_in) begin
    if (rst !== 1'b1) begin
      m_src = 0; m_left = 0; m_ack = 0; m_cnt = 0;
    end else begin
`ifdef STALL_SCHED_PERF_EN
      if (m_src != 0 && m_cnt < CMAX) m_cnt = m_cnt + 1;
`endif
      m_ack = 0;
      if (flush_req) begin
        m_src = 4; m_left = DRAIN;
      end else if (m_src == 0) begin
        if (mem_wait) m_src = 3;
        else if (mc_req) begin
          m_src = 2; m_left = (int'(mc_len) > 1) ? int'(mc_len) : 1; m_ack = 1;
        end else if (ld_use_hz) begin
          m_src = 1; m_left = HAZ;
        end
      end else if (m_src == 3) begin
        if (!mem_wait) m_src = 0;
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) m_src = 0;
      end
    end
  end

  always @(negedge clk_in) begin
    check("model_stallb_en", int'(stallb_en), (m_src == 0) ? 1 : 0);
    check("model_stall_src", int'(stall_src), m_src);
    check("model_mc_ack",    int'(mc_ack),    m_ack);
    check("model_stall_cnt", int'(stall_cnt), m_cnt);
  end

  initial begin
    int low;
    rst = 1'b0; ld_use_hz = 1'b1; mc_req = 1'b1; mc_len = 4'd5; mem_wait = 1'b1; flush_req = 1'b1;

    // Reset held with every request asserted.
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_en",  int'(stallb_en), 1);
      check("rst_src", int'(stall_src), 0);
      check("rst_ack", int'(mc_ack), 0);
      check("rst_cnt", int'(stall_cnt), 0);
    end
    rst = 1'b1; ld_use_hz = 1'b0; mc_req = 1'b0; mem_wait = 1'b0; flush_req = 1'b0;
    tick();

    // Single hazard pulse, then held hazard alternates low/high.
    ld_use_hz = 1'b1; tick();
    check("haz_low", int'(stallb_en), 0);
    check("haz_src", int'(stall_src), 1);
    ld_use_hz = 1'b0; tick();
    check("haz_end", int'(stallb_en), 1);
    ld_use_hz = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("haz_alt", int'(stallb_en), i % 2);
    end
    ld_use_hz = 1'b0;

    // Multi-cycle of length 5, then length 0.
    mc_req = 1'b1; mc_len = 4'd5; tick();
    check("mc_ack", int'(mc_ack), 1);
    check("mc_src", int'(stall_src), 2);
    mc_req = 1'b0;
    low = 0;
    for (int i = 0; i < 20 && stallb_en == 1'b0; i++) begin
      low++; tick();
    end
    check("mc5_low_cycles", low, 5);
    mc_req = 1'b1; mc_len = 4'd0; tick();
    check("mc0_low", int'(stallb_en), 0);
    mc_req = 1'b0; tick();
    check("mc0_end", int'(stallb_en), 1);

    // Priority: memory wait wins, MC accepted after one run cycle.
    mem_wait = 1'b1; mc_req = 1'b1; ld_use_hz = 1'b1; mc_len = 4'd2; tick();
    check("prio_src", int'(stall_src), 3);
    check("prio_noack", int'(mc_ack), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("memw_low", int'(stallb_en), 0);
    end
    mem_wait = 1'b0; tick();
    check("memw_run", int'(stallb_en), 1);
    check("memw_run_noack", int'(mc_ack), 0);
    tick();
    check("prio_mc_ack", int'(mc_ack), 1);
    check("prio_mc_src", int'(stall_src), 2);
    mc_req = 1'b0; ld_use_hz = 1'b0;
    tick(); tick();
    check("prio_mc_end", int'(stallb_en), 1);

    // Flush preempting an MC stall in its first stall cycle.
    mc_req = 1'b1; mc_len = 4'd6; tick();
    check("fl_mc_src", int'(stall_src), 2);
    mc_req = 1'b0; flush_req = 1'b1; tick();
    check("fl_src", int'(stall_src), 4);
    flush_req = 1'b0;
    tick(); check("fl_src2", int'(stall_src), 4);
    tick(); check("fl_src3", int'(stall_src), 4);
    tick(); check("fl_end", int'(stallb_en), 1);

    // Reset in the middle of MEMW.
    mem_wait = 1'b1; tick(); tick();
    check("rmw_src", int'(stall_src), 3);
    rst = 1'b0; tick();
    check("rmw_en", int'(stallb_en), 1);
    check("rmw_cnt", int'(stall_cnt), 0);
    rst = 1'b1; mem_wait = 1'b0; tick();

`ifdef STALL_SCHED_PERF_EN
    mem_wait = 1'b1;
    repeat (300) tick();
    check("cnt_saturate", int'(stall_cnt), CMAX);
    mem_wait = 1'b0; tick(); tick();
    check("cnt_hold", int'(stall_cnt), CMAX);
`endif

    // Randomized traffic, checked every cycle by the model compare process.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) != 0);
      flush_req = ($urandom_range(0, 99) < 4);
      mem_wait  = ($urandom_range(0, 99) < 15);
      mc_req    = ($urandom_range(0, 99) < 25);
      ld_use_hz = ($urandom_range(0, 99) < 30);
      mc_len    = MCW'($urandom_range(0, 15));
      tick();
    end
    rst = 1'b1; flush_req = 1'b0; mem_wait = 1'b0; mc_req = 1'b0; ld_use_hz = 1'b0;
    repeat (20) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
